// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator with pixel-rate counters, sync,
//               blank and frame-start decodes. Define VGA_PIPE_ALIGN_EN to
//               delay hsync/vsync/blank_n by one extra pixel period.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] next_x,
    output logic [31:0] next_y,
    output logic        vga_clk,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        sync_n,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       pix_en;
    logic [9:0] h_count;
    logic [9:0] v_count;

    logic hsync_dec;
    logic vsync_dec;
    logic blank_dec;
    logic fs_dec;

    logic hsync_q;
    logic vsync_q;
    logic blank_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_en  <= 1'b0;
            vga_clk <= 1'b0;
        end else begin
            pix_en  <= ~pix_en;
            vga_clk <= pix_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_count <= 10'd0;
            v_count <= 10'd0;
        end else if (pix_en) begin
            if (h_count == H_LAST) begin
                h_count <= 10'd0;
                if (v_count == V_LAST) begin
                    v_count <= 10'd0;
                end else begin
                    v_count <= v_count + 10'd1;
                end
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    // fs_dec marks only the first of the two clocks spent at (0,0)
    always_comb begin
        hsync_dec = 1'b1;
        vsync_dec = 1'b1;
        blank_dec = 1'b0;
        fs_dec    = 1'b0;
        if ((h_count >= HS_START) && (h_count < HS_END)) begin
            hsync_dec = 1'b0;
        end
        if ((v_count >= VS_START) && (v_count < VS_END)) begin
            vsync_dec = 1'b0;
        end
        if ((h_count < H_VIS) && (v_count < V_VIS)) begin
            blank_dec = 1'b1;
        end
        if ((h_count == 10'd0) && (v_count == 10'd0) && !pix_en) begin
            fs_dec = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            blank_q     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync_q     <= hsync_dec;
            vsync_q     <= vsync_dec;
            blank_q     <= blank_dec;
            frame_start <= fs_dec;
        end
    end

`ifdef VGA_PIPE_ALIGN_EN
    // Extra pixel period of delay to line up with the pixel memory read
    logic hsync_p1;
    logic vsync_p1;
    logic blank_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
            blank_p1 <= 1'b0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            blank_n  <= 1'b0;
        end else begin
            hsync_p1 <= hsync_q;
            vsync_p1 <= vsync_q;
            blank_p1 <= blank_q;
            hsync    <= hsync_p1;
            vsync    <= vsync_p1;
            blank_n  <= blank_p1;
        end
    end
`else
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign blank_n = blank_q;
`endif

    assign next_x = {22'd0, h_count};
    assign next_y = {22'd0, v_count};
    assign sync_n = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen; a small-raster and a
//               default-raster instance share clock and random resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

`ifdef VGA_PIPE_ALIGN_EN
    localparam int LAG = 3;
`else
    localparam int LAG = 1;
`endif

    // Small raster: 15 x 8 positions, so full frames fit in a short run
    localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 1;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } pair_t;

    logic clk;
    logic rst;

    logic [31:0] a_x, a_y, b_x, b_y;
    logic a_vclk, a_hs, a_vs, a_bl, a_sn, a_fs;
    logic b_vclk, b_hs, b_vs, b_bl, b_sn, b_fs;

    int n_checks;
    int n_fail;
    int k;
    int max_ax, max_ay, max_bx, max_by;
    pair_t q[$];

    vga_timing_gen #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) u_small (
        .clk         (clk),
        .rst         (rst),
        .next_x      (a_x),
        .next_y      (a_y),
        .vga_clk     (a_vclk),
        .hsync       (a_hs),
        .vsync       (a_vs),
        .blank_n     (a_bl),
        .sync_n      (a_sn),
        .frame_start (a_fs)
    );

    vga_timing_gen u_dflt (
        .clk         (clk),
        .rst         (rst),
        .next_x      (b_x),
        .next_y      (b_y),
        .vga_clk     (b_vclk),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .blank_n     (b_bl),
        .sync_n      (b_sn),
        .frame_start (b_fs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs after the kk-th rising edge since reset release,
    // derived from elapsed time: positions advance once per two clocks.
    function automatic exp_t model(input int kk, input int ha, input int hf,
                                   input int hs, input int hb, input int va,
                                   input int vf, input int vs, input int vb);
        exp_t e;
        int ht, vt, ft, p, j, pos, hx, vy;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        ft = ht * vt;
        p = (kk / 2) % ft;
        e.x = 32'(p % ht);
        e.y = 32'(p / ht);
        e.vclk = ((kk % 2) == 0);
        j = kk - LAG;
        if (j < 0) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            e.bl = 1'b0;
        end else begin
            pos = (j / 2) % ft;
            hx = pos % ht;
            vy = pos / ht;
            e.hs = !((hx >= ha + hf) && (hx < ha + hf + hs));
            e.vs = !((vy >= va + vf) && (vy < va + vf + vs));
            e.bl = (hx < ha) && (vy < va);
        end
        j = kk - 1;
        e.fs = ((j % 2) == 0) && (((j / 2) % ft) == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input exp_t act, input logic sn);
        chk({tag, ".next_x"},      act.x,    e.x);
        chk({tag, ".next_y"},      act.y,    e.y);
        chk({tag, ".vga_clk"},     act.vclk, e.vclk);
        chk({tag, ".hsync"},       act.hs,   e.hs);
        chk({tag, ".vsync"},       act.vs,   e.vs);
        chk({tag, ".blank_n"},     act.bl,   e.bl);
        chk({tag, ".frame_start"}, act.fs,   e.fs);
        chk({tag, ".sync_n"},      sn,       1'b0);
    endtask

    function automatic exp_t rst_vals();
        exp_t e;
        e.x = 32'd0;
        e.y = 32'd0;
        e.vclk = 1'b0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        e.bl = 1'b0;
        e.fs = 1'b0;
        return e;
    endfunction

    task automatic reset_check(input string tag);
        cmp({tag, "_small"}, rst_vals(), {a_x, a_y, a_vclk, a_hs, a_vs, a_bl, a_fs}, a_sn);
        cmp({tag, "_dflt"},  rst_vals(), {b_x, b_y, b_vclk, b_hs, b_vs, b_bl, b_fs}, b_sn);
    endtask

    // Producer: one expected response per rising edge outside reset
    initial begin : producer
        forever begin
            @(posedge clk);
            if (!rst) begin
                k++;
                q.push_back('{a: model(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB),
                              b: model(k, 640, 16, 96, 48, 480, 10, 2, 33)});
            end
        end
    end

    // Monitor: compares on the falling edge, away from the active edge
    initial begin : monitor
        pair_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("small", e.a, {a_x, a_y, a_vclk, a_hs, a_vs, a_bl, a_fs}, a_sn);
                cmp("dflt",  e.b, {b_x, b_y, b_vclk, b_hs, b_vs, b_bl, b_fs}, b_sn);
                if (int'(a_x) > max_ax) max_ax = int'(a_x);
                if (int'(a_y) > max_ay) max_ay = int'(a_y);
                if (int'(b_x) > max_bx) max_bx = int'(b_x);
                if (int'(b_y) > max_by) max_by = int'(b_y);
            end else if (rst) begin
                reset_check("rst_hold");
            end
        end
    end

    initial begin : stimulus
        int d;
        n_checks = 0;
        n_fail = 0;
        k = 0;
        max_ax = 0;
        max_ay = 0;
        max_bx = 0;
        max_by = 0;
        rst = 1'b1;
        #1 reset_check("rst_init");
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Covers first default line, first hsync and several small frames
        repeat (3500) @(negedge clk);

        // Asynchronous mid-frame resets at random points
        for (int i = 0; i < 8; i++) begin
            d = int'($urandom_range(1, 3));
            #d rst = 1'b1;
            k = 0;
            q.delete();
            #1 reset_check("rst_async");
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #1 rst = 1'b0;
            repeat ($urandom_range(50, 800)) @(negedge clk);
        end
        repeat (400) @(negedge clk);

        chk("small_max_x", 32'(max_ax), 32'(SHA + SHF + SHS + SHB - 1));
        chk("small_max_y", 32'(max_ay), 32'(SVA + SVF + SVS + SVB - 1));
        chk("dflt_x_below_800", {31'd0, (max_bx < 800)}, 32'd1);
        chk("dflt_reached_799", 32'(max_bx), 32'd799);
        chk("dflt_y_below_525", {31'd0, (max_by < 525)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
